// File: rtl/pipelined_vector_adder_pkg.sv
// Shared types and helpers for the pipelined SIMD vector adder.
// Holds the sew encoding, byte-lane width and element-boundary mask helper.
package pipelined_vector_adder_pkg;

  localparam int LANE = 8;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } sew_e;

  // Bit i set when byte i is the lowest byte of an element.
  function automatic logic [7:0] bnd_mask(input sew_e s);
    logic [7:0] m;
    m = 8'h01;
    unique case (s)
      SEW8:  m = 8'hFF;
      SEW16: m = 8'h55;
      SEW32: m = 8'h11;
      SEW64: m = 8'h01;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pipelined_vector_adder_segment_adder.sv
// One combinational adder segment of NB byte lanes.
// Ports: a/b operands, sub, cin (chained), bnd (per-byte element start), sum, co (per-byte carry), cout.
module segment_adder
  import pipelined_vector_adder_pkg::*;
#(
  parameter int NB = 2
) (
  input  logic [NB*LANE-1:0] a,
  input  logic [NB*LANE-1:0] b,
  input  logic               sub,
  input  logic               cin,
  input  logic [NB-1:0]      bnd,
  output logic [NB*LANE-1:0] sum,
  output logic [NB-1:0]      co,
  output logic               cout
);

  logic [NB*LANE-1:0] bx;
  logic [LANE:0]      t;
  logic               c;
  logic               ci;

  assign bx = b ^ {(NB*LANE){sub}};

  always_comb begin
    sum = '0;
    co  = '0;
    t   = '0;
    ci  = 1'b0;
    c   = cin;
    for (int i = 0; i < NB; i++) begin
      // An element start takes the subtract carry-in, never the chain.
      ci = bnd[i] ? sub : c;
      t  = {1'b0, a[i*LANE +: LANE]}
         + {1'b0, bx[i*LANE +: LANE]}
         + {{LANE{1'b0}}, ci};
      sum[i*LANE +: LANE] = t[LANE-1:0];
      co[i] = t[LANE];
      c     = t[LANE];
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_vector_adder.sv
// Pipelined SIMD add/sub: one WIDTH/STAGES-bit segment per stage, valid/ready flow.
// Ports: clk, rst, in_valid/in_ready, a, b, sub, sew, out_valid/out_ready, sum, carry.
module pipelined_vector_adder
  import pipelined_vector_adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  sub,
  input  logic [1:0]            sew,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      sum,
  output logic [WIDTH/LANE-1:0] carry
);

  localparam int SEG    = WIDTH / STAGES;
  localparam int NB     = SEG / LANE;
  localparam int NBYTES = WIDTH / LANE;

  logic              v_q   [STAGES];
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  y_q   [STAGES];
  logic [NBYTES-1:0] c_q   [STAGES];
  logic              sub_q [STAGES];
  logic [1:0]        sew_q [STAGES];
  logic              ci_q  [STAGES];

  logic              s_v   [STAGES];
  logic [WIDTH-1:0]  s_x   [STAGES];
  logic [WIDTH-1:0]  s_y   [STAGES];
  logic [NBYTES-1:0] s_c   [STAGES];
  logic              s_sub [STAGES];
  logic [1:0]        s_sew [STAGES];
  logic              s_ci  [STAGES];

  logic [WIDTH-1:0]  n_x   [STAGES];
  logic [NBYTES-1:0] n_c   [STAGES];
  logic              n_ci  [STAGES];

  logic adv;

  assign adv       = !v_q[STAGES-1] || out_ready;
  assign in_ready  = rst || adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = x_q[STAGES-1];
  assign carry     = c_q[STAGES-1];

  // x holds finished sum segments below k and operand A above;
  // y holds operand B for segments still to be computed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] M =
      WIDTH'({SEG{1'b1}}) << (k*SEG);

    logic [SEG-1:0]    seg_s;
    logic [NB-1:0]     seg_co;
    logic              seg_cout;
    logic [NBYTES-1:0] bm;
    logic [NBYTES-1:0] tm;
    logic [NBYTES:0]   tx;

    if (k == 0) begin : g_in
      assign s_v[k]   = in_valid;
      assign s_x[k]   = a;
      assign s_y[k]   = b;
      assign s_c[k]   = '0;
      assign s_sub[k] = sub;
      assign s_sew[k] = sew;
      assign s_ci[k]  = 1'b0;
    end else begin : g_reg
      assign s_v[k]   = v_q[k-1];
      assign s_x[k]   = x_q[k-1];
      assign s_y[k]   = y_q[k-1];
      assign s_c[k]   = c_q[k-1];
      assign s_sub[k] = sub_q[k-1];
      assign s_sew[k] = sew_q[k-1];
      assign s_ci[k]  = ci_q[k-1];
    end

    assign bm = NBYTES'(bnd_mask(sew_e'(s_sew[k])));
    // Top byte of an element sits just below the next element start.
    assign tx = {1'b1, bm};
    assign tm = tx[NBYTES:1];

    segment_adder #(.NB(NB)) u_seg (
      .a    (s_x[k][k*SEG +: SEG]),
      .b    (s_y[k][k*SEG +: SEG]),
      .sub  (s_sub[k]),
      .cin  (s_ci[k]),
      .bnd  (bm[k*NB +: NB]),
      .sum  (seg_s),
      .co   (seg_co),
      .cout (seg_cout)
    );

    assign n_x[k]  = (s_x[k] & ~M)
                   | (WIDTH'(seg_s) << (k*SEG));
    assign n_c[k]  = s_c[k]
                   | (NBYTES'(seg_co & tm[k*NB +: NB]) << (k*NB));
    assign n_ci[k] = seg_cout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        c_q[k]   <= '0;
        sub_q[k] <= 1'b0;
        sew_q[k] <= '0;
        ci_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= s_v[k];
        x_q[k]   <= n_x[k];
        y_q[k]   <= s_y[k];
        c_q[k]   <= n_c[k];
        sub_q[k] <= s_sub[k];
        sew_q[k] <= s_sew[k];
        ci_q[k]  <= n_ci[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_vector_adder.sv
// Scoreboard bench: 4-stage DUT with directed vectors and stalls,
// plus 8-stage and 1-stage copies checked against a per-element model.
module tb_pipelined_vector_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sub;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  sew;

  logic        rdy [3];
  logic        ov  [3];
  logic [63:0] sm  [3];
  logic [7:0]  cy  [3];

  logic [71:0] sbq [3][$];
  logic [71:0] cur_exp;
  logic [71:0] held;
  logic        stall_seen;
  logic        rnd_done;
  int          pass_n = 0;
  int          tot_n  = 0;

  logic [63:0] va [10];
  logic [63:0] vb [10];
  logic        vs [10];
  logic [1:0]  vw [10];
  logic [71:0] ve [10];

  always #5 clk = ~clk;

  pipelined_vector_adder #(.WIDTH(64), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .sub(sub), .sew(sew), .out_valid(ov[0]),
    .out_ready(out_ready), .sum(sm[0]), .carry(cy[0])
  );

  pipelined_vector_adder #(.WIDTH(64), .STAGES(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .sub(sub), .sew(sew), .out_valid(ov[1]),
    .out_ready(1'b1), .sum(sm[1]), .carry(cy[1])
  );

  pipelined_vector_adder #(.WIDTH(64), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .sub(sub), .sew(sew), .out_valid(ov[2]),
    .out_ready(1'b1), .sum(sm[2]), .carry(cy[2])
  );

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [71:0] ref_add(input logic [63:0] x,
      input logic [63:0] y, input logic s, input logic [1:0] w);
    int          ew;
    logic [63:0] rs;
    logic [7:0]  rc;
    logic [64:0] m, ea, eb, r, t;
    ew = 8 << w;
    rs = '0;
    rc = '0;
    m  = (65'd1 << ew) - 65'd1;
    for (int e = 0; e < 64 / ew; e++) begin
      ea = ({1'b0, x} >> (e*ew)) & m;
      eb = ({1'b0, y} >> (e*ew)) & m;
      if (s) eb = ~eb & m;
      r  = ea + eb + 65'(s);
      t  = (r & m) << (e*ew);
      rs = rs | t[63:0];
      rc[(e*ew + ew)/8 - 1] = r[ew];
    end
    return {rc, rs};
  endfunction

  // Monitor: pops expected results, records accepts, checks stall behaviour.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) sbq[d].delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", 72'(ov[0]), 72'd1);
        chk("hold_data", {cy[0], sm[0]}, held);
      end
      if (ov[0] && !out_ready) chk("in_ready_stall", 72'(rdy[0]), 72'd0);
      stall_seen = ov[0] && !out_ready;
      held = {cy[0], sm[0]};
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && (d != 0 || out_ready)) begin
          if (sbq[d].size() == 0) begin
            tot_n++;
            $display("FAIL unexpected_out dut%0d: got %h want none",
                     d, {cy[d], sm[d]});
          end else begin
            chk($sformatf("result_dut%0d", d), {cy[d], sm[d]},
                sbq[d].pop_front());
          end
        end
        if (in_valid && rdy[d]) sbq[d].push_back(cur_exp);
      end
    end
  end

  task automatic send(input int i);
    @(posedge clk); #1;
    a = va[i]; b = vb[i]; sub = vs[i]; sew = vw[i];
    cur_exp = ve[i]; in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (rdy[0]) break;
      if (n > 50) begin
        tot_n++;
        $display("FAIL accept_timeout: got stuck want accept");
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic latency_test(input int i);
    int lat;
    send(i);
    idle();
    lat = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ov[0]) break;
      lat++;
    end
    chk("latency", 72'(lat), 72'd4);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sbq[0].size() == 0 && sbq[1].size() == 0 &&
          sbq[2].size() == 0) break;
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("drain_dut%0d", d), 72'(sbq[d].size()), 72'd0);
  endtask

  initial begin
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1;
    vs[0] = 0; vw[0] = 2'b11; ve[0] = {8'h80, 64'h0};
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h0101_0101_0101_0101;
    vs[1] = 0; vw[1] = 2'b00; ve[1] = {8'hFF, 64'h0};
    va[2] = 64'h0000_0001_0002_0003; vb[2] = 64'h0001_0001_0001_0001;
    vs[2] = 1; vw[2] = 2'b01; ve[2] = {8'h2A, 64'hFFFF_0000_0001_0002};
    va[3] = 64'h0000_0000_FFFF_FFFF; vb[3] = 64'h0000_0001_0000_0001;
    vs[3] = 0; vw[3] = 2'b10; ve[3] = {8'h08, 64'h0000_0001_0000_0000};
    va[4] = 64'h0102_0304_0506_0708; vb[4] = 64'h0101_0101_0101_0101;
    vs[4] = 1; vw[4] = 2'b00; ve[4] = {8'hFF, 64'h0001_0203_0405_0607};
    va[5] = 64'h0; vb[5] = 64'h1;
    vs[5] = 1; vw[5] = 2'b11; ve[5] = {8'h00, 64'hFFFF_FFFF_FFFF_FFFF};
    va[6] = 64'h00FF_00FF_00FF_00FF; vb[6] = 64'h0001_0001_0001_0001;
    vs[6] = 0; vw[6] = 2'b01; ve[6] = {8'h00, 64'h0100_0100_0100_0100};
    va[7] = 64'h0000_FFFF_0000_FFFF; vb[7] = 64'h0000_0001_0000_0001;
    vs[7] = 0; vw[7] = 2'b10; ve[7] = {8'h00, 64'h0001_0000_0001_0000};
    va[8] = 64'h0000_0000_FFFF_FFFF; vb[8] = 64'h1;
    vs[8] = 0; vw[8] = 2'b11; ve[8] = {8'h00, 64'h0000_0001_0000_0000};
    va[9] = 64'h0000_0005_0000_0003; vb[9] = 64'h0000_0003_0000_0005;
    vs[9] = 1; vw[9] = 2'b10; ve[9] = {8'h80, 64'h0000_0002_FFFF_FFFE};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; sew = 2'b00; cur_exp = '0;
    stall_seen = 1'b0; held = '0; rnd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 72'(ov[0]), 72'd0);
    chk("rst_sum", 72'(sm[0]), 72'd0);
    chk("rst_carry", 72'(cy[0]), 72'd0);
    chk("rst_in_ready", 72'(rdy[0]), 72'd1);

    latency_test(0);
    for (int i = 1; i < 10; i++) send(i);
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) send(i);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send(i + 3);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_in_rst", 72'(rdy[0]), 72'd1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 72'(ov[0]), 72'd0);
    chk("post_rst_sum", {cy[0], sm[0]}, 72'd0);
    chk("post_rst_in_ready", 72'(rdy[0]), 72'd1);
    repeat (8) @(negedge clk);
    chk("no_stale_out", 72'(ov[0]), 72'd0);
    latency_test(9);
    drain();

    fork
      begin
        for (int n = 0; n < 60; n++) begin
          va[0] = {$urandom, $urandom};
          vb[0] = {$urandom, $urandom};
          vs[0] = 1'($urandom_range(1));
          vw[0] = 2'($urandom_range(3));
          ve[0] = ref_add(va[0], vb[0], vs[0], vw[0]);
          send(0);
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
